// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if
// Purpose: groups the fetch (I), data (D) and unified memory handshake
//          signals that connect the hart-side requesters and the memory
//          to mem_arbiter.
// Modports:
//   slave  - the arbiter's view: takes requests and memory responses in,
//            drives grants, responses and the memory request out.
//   master - the environment's view (requesters plus memory), the mirror
//            image of slave.
// Signals:
//   i_i_req/i_i_addr, o_i_ready/o_i_valid/o_i_rdata/o_i_err   fetch port
//   i_d_req/i_d_addr/i_d_wen/i_d_wdata/i_d_mask,
//   o_d_ready/o_d_valid/o_d_rdata/o_d_err                     data port
//   o_mem_req/o_mem_addr/o_mem_wen/o_mem_wdata/o_mem_mask,
//   i_mem_ready/i_mem_valid/i_mem_rdata                       memory port
interface mem_arbiter_if;
    // Fetch requester
    logic        i_i_req;
    logic [31:0] i_i_addr;
    logic        o_i_ready;
    logic        o_i_valid;
    logic [31:0] o_i_rdata;
    logic        o_i_err;

    // Data requester
    logic        i_d_req;
    logic [31:0] i_d_addr;
    logic        i_d_wen;
    logic [31:0] i_d_wdata;
    logic [3:0]  i_d_mask;
    logic        o_d_ready;
    logic        o_d_valid;
    logic [31:0] o_d_rdata;
    logic        o_d_err;

    // Unified memory port
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        o_mem_wen;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_mask;
    logic        i_mem_ready;
    logic        i_mem_valid;
    logic [31:0] i_mem_rdata;

    modport slave (
        input  i_i_req, i_i_addr,
        output o_i_ready, o_i_valid, o_i_rdata, o_i_err,
        input  i_d_req, i_d_addr, i_d_wen, i_d_wdata, i_d_mask,
        output o_d_ready, o_d_valid, o_d_rdata, o_d_err,
        output o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        input  i_mem_ready, i_mem_valid, i_mem_rdata
    );

    modport master (
        output i_i_req, i_i_addr,
        input  o_i_ready, o_i_valid, o_i_rdata, o_i_err,
        output i_d_req, i_d_addr, i_d_wen, i_d_wdata, i_d_mask,
        input  o_d_ready, o_d_valid, o_d_rdata, o_d_err,
        input  o_mem_req, o_mem_addr, o_mem_wen, o_mem_wdata, o_mem_mask,
        output i_mem_ready, i_mem_valid, i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Purpose: shares one multi-cycle unified memory port between the
//          instruction-fetch requester (I) and the data load/store
//          requester (D). One transaction is in flight at a time
//          (IDLE -> ISSUE -> WAIT -> IDLE, or IDLE -> ERR -> IDLE).
//          D has priority on conflicts; after STARVE_LIMIT consecutive
//          conflicting D grants, I wins the next conflict. Misaligned
//          requests are answered locally with an error response and never
//          reach memory.
// Parameters:
//   STARVE_LIMIT - conflicting D grants before I is forced through (>= 1)
//   CNT_W        - starvation counter width, 2**CNT_W > STARVE_LIMIT
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset; all outputs are 0 while low
//   bus     - mem_arbiter_if.slave: I/D request/response and memory ports
//   o_busy  - a transaction is in progress (state != IDLE)
module mem_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    mem_arbiter_if.slave bus,
    output logic         o_busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_ERR
    } state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } owner_t;

    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

    // State and latched request
    state_t           r_state;
    owner_t           r_owner;
    logic [CNT_W-1:0] r_cnt;
    logic [29:0]      r_waddr;   // word address; byte offset is only needed for the alignment check
    logic             r_wen;
    logic [31:0]      r_wdata;
    logic [3:0]       r_mask;

    state_t           w_state_nxt;
    owner_t           w_owner_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [29:0]      w_waddr_nxt;
    logic             w_wen_nxt;
    logic [31:0]      w_wdata_nxt;
    logic [3:0]       w_mask_nxt;

    // Arbitration
    logic w_starved;
    logic w_grant_i;
    logic w_grant_d;

    // Combinational outputs before the reset gate is applied
    logic        w_i_ready;
    logic        w_i_valid;
    logic [31:0] w_i_rdata;
    logic        w_i_err;
    logic        w_d_ready;
    logic        w_d_valid;
    logic [31:0] w_d_rdata;
    logic        w_d_err;
    logic        w_mem_req;
    logic [31:0] w_mem_addr;
    logic        w_mem_wen;
    logic [31:0] w_mem_wdata;
    logic [3:0]  w_mem_mask;

    // A D access is legal when it is a naturally aligned word, a half on an
    // even address, or any single byte lane. Every other mask is rejected.
    function automatic logic f_d_misaligned(input logic [1:0] lsb, input logic [3:0] mask);
        case (mask)
            4'b1111:                            return lsb != 2'b00;
            4'b0011, 4'b1100:                   return lsb[0];
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b0;
            default:                            return 1'b1;
        endcase
    endfunction

    assign w_starved = (r_cnt == LIMIT_C);

    // Grants are only possible from IDLE; D wins conflicts unless I has
    // been held off STARVE_LIMIT times in a row.
    always_comb begin
        w_grant_i = 1'b0;
        w_grant_d = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.i_d_req && bus.i_i_req) begin
                if (w_starved) begin
                    w_grant_i = 1'b1;
                end else begin
                    w_grant_d = 1'b1;
                end
            end else if (bus.i_d_req) begin
                w_grant_d = 1'b1;
            end else if (bus.i_i_req) begin
                w_grant_i = 1'b1;
            end
        end
    end

    // State register and latched request fields
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_owner <= OWN_I;
            r_cnt   <= '0;
            r_waddr <= '0;
            r_wen   <= 1'b0;
            r_wdata <= '0;
            r_mask  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_cnt   <= w_cnt_nxt;
            r_waddr <= w_waddr_nxt;
            r_wen   <= w_wen_nxt;
            r_wdata <= w_wdata_nxt;
            r_mask  <= w_mask_nxt;
        end
    end

    // Next state and outputs
    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_waddr_nxt = r_waddr;
        w_wen_nxt   = r_wen;
        w_wdata_nxt = r_wdata;
        w_mask_nxt  = r_mask;

        w_i_ready   = 1'b0;
        w_i_valid   = 1'b0;
        w_i_rdata   = '0;
        w_i_err     = 1'b0;
        w_d_ready   = 1'b0;
        w_d_valid   = 1'b0;
        w_d_rdata   = '0;
        w_d_err     = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_addr  = '0;
        w_mem_wen   = 1'b0;
        w_mem_wdata = '0;
        w_mem_mask  = '0;

        case (r_state)
            S_IDLE: begin
                if (w_grant_d) begin
                    w_d_ready   = 1'b1;
                    w_owner_nxt = OWN_D;
                    w_waddr_nxt = bus.i_d_addr[31:2];
                    w_wen_nxt   = bus.i_d_wen;
                    w_wdata_nxt = bus.i_d_wdata;
                    w_mask_nxt  = bus.i_d_mask;
                    // Only a D grant that actually held I off counts toward starvation.
                    if (bus.i_i_req && !w_starved) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                    w_state_nxt = f_d_misaligned(bus.i_d_addr[1:0], bus.i_d_mask) ? S_ERR : S_ISSUE;
                end else if (w_grant_i) begin
                    w_i_ready   = 1'b1;
                    w_owner_nxt = OWN_I;
                    w_waddr_nxt = bus.i_i_addr[31:2];
                    w_wen_nxt   = 1'b0;
                    w_wdata_nxt = '0;
                    w_mask_nxt  = 4'b1111;
                    w_cnt_nxt   = '0;
                    w_state_nxt = (bus.i_i_addr[1:0] != 2'b00) ? S_ERR : S_ISSUE;
                end
            end

            S_ISSUE: begin
                w_mem_req   = 1'b1;
                w_mem_addr  = {r_waddr, 2'b00};
                w_mem_wen   = r_wen;
                w_mem_wdata = r_wdata;
                w_mem_mask  = r_mask;
                // A valid arriving together with ready is not a completion.
                if (bus.i_mem_ready) begin
                    w_state_nxt = S_WAIT;
                end
            end

            S_WAIT: begin
                if (bus.i_mem_valid) begin
                    if (r_owner == OWN_D) begin
                        w_d_valid = 1'b1;
                        w_d_rdata = bus.i_mem_rdata;
                    end else begin
                        w_i_valid = 1'b1;
                        w_i_rdata = bus.i_mem_rdata;
                    end
                    w_state_nxt = S_IDLE;
                end
            end

            S_ERR: begin
                if (r_owner == OWN_D) begin
                    w_d_valid = 1'b1;
                    w_d_err   = 1'b1;
                end else begin
                    w_i_valid = 1'b1;
                    w_i_err   = 1'b1;
                end
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Ready is combinational from the request inputs, so it must be
        // forced low while reset is held even though the state is IDLE.
        if (!i_rst_n) begin
            w_i_ready   = 1'b0;
            w_i_valid   = 1'b0;
            w_i_rdata   = '0;
            w_i_err     = 1'b0;
            w_d_ready   = 1'b0;
            w_d_valid   = 1'b0;
            w_d_rdata   = '0;
            w_d_err     = 1'b0;
            w_mem_req   = 1'b0;
            w_mem_addr  = '0;
            w_mem_wen   = 1'b0;
            w_mem_wdata = '0;
            w_mem_mask  = '0;
        end
    end

    assign bus.o_i_ready   = w_i_ready;
    assign bus.o_i_valid   = w_i_valid;
    assign bus.o_i_rdata   = w_i_rdata;
    assign bus.o_i_err     = w_i_err;
    assign bus.o_d_ready   = w_d_ready;
    assign bus.o_d_valid   = w_d_valid;
    assign bus.o_d_rdata   = w_d_rdata;
    assign bus.o_d_err     = w_d_err;
    assign bus.o_mem_req   = w_mem_req;
    assign bus.o_mem_addr  = w_mem_addr;
    assign bus.o_mem_wen   = w_mem_wen;
    assign bus.o_mem_wdata = w_mem_wdata;
    assign bus.o_mem_mask  = w_mem_mask;

    assign o_busy = i_rst_n && (r_state != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// Purpose: self-checking bench for mem_arbiter. Requesters and memory are
//          modelled at transaction level: each request is held until its
//          grant, the memory accepts after a random stall and completes
//          after a random latency, and a word-array memory applies writes.
//          Expected grants, responses and memory fields come from this
//          model; a few directed transactions cover the listed scenarios.
module tb_mem_arbiter;
    localparam int unsigned LIMIT = 4;
    localparam logic [3:0] BAD_MASKS [9] = '{4'h0, 4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hD, 4'hE};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;

    always #5 clk = ~clk;

    mem_arbiter_if bus();

    mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus),
        .o_busy (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Requesters: a pending request is held until granted (or dropped)
    logic        i_pend = 1'b0;
    logic [31:0] i_a    = '0;
    logic        d_pend = 1'b0;
    logic [31:0] d_a    = '0;
    logic        d_we   = 1'b0;
    logic [31:0] d_wd   = '0;
    logic [3:0]  d_m    = '0;

    // Transaction in flight
    logic        t_open = 1'b0;
    logic        t_own_d, t_err, t_acc, t_we;
    logic [31:0] t_a, t_wd, t_rd;
    logic [3:0]  t_m;
    int          t_due;
    int          streak = 0;   // consecutive D wins while I was waiting

    // Knobs (percentages / latency range)
    int unsigned p_i = 0, p_d = 0, p_mis = 0, p_drop = 0, p_rdy = 100, p_spur = 0;
    int unsigned lat_lo = 1, lat_hi = 1;

    // Observations of the DUT for directed checks
    int          gnt_cyc = 0, rsp_cyc = 0;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic [31:0] acc_addr, acc_wdata;
    logic [3:0]  acc_mask;
    logic        acc_wen;
    logic        mreq_seen = 1'b0;
    int          gnt_log[$];

    logic [31:0] mem_q [logic [29:0]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [29:0] w);
        if (mem_q.exists(w)) return mem_q[w];
        return {w, 2'b00} ^ 32'hA5A5_1234;
    endfunction

    function automatic logic mis_d(input logic [31:0] a, input logic [3:0] m);
        if (m == 4'hF) return (a % 4) != 0;
        if (m == 4'h3 || m == 4'hC) return (a % 2) != 0;
        return $countones(m) != 1;
    endfunction

    task automatic new_i();
        i_a = 32'($urandom_range(0, 63)) << 2;
        if ($urandom_range(0, 99) < p_mis) i_a[1:0] = 2'($urandom_range(1, 3));
        i_pend = 1'b1;
    endtask

    task automatic new_d();
        int unsigned k;
        int unsigned lane;
        logic        mis;
        k    = $urandom_range(0, 9);
        mis  = ($urandom_range(0, 99) < p_mis);
        d_a  = 32'($urandom_range(0, 63)) << 2;
        d_we = ($urandom_range(0, 1) == 1);
        d_wd = $urandom();
        if (k < 4 || (k == 9 && !mis)) begin
            d_m = 4'hF;
            if (mis) d_a[1:0] = 2'($urandom_range(1, 3));
        end else if (k < 7) begin
            lane    = $urandom_range(0, 1);
            d_m     = (lane == 1) ? 4'b1100 : 4'b0011;
            d_a[1]  = (lane == 1);
            if (mis) d_a[0] = 1'b1;
        end else if (k < 9) begin
            lane     = $urandom_range(0, 3);
            d_a[1:0] = 2'(lane);
            d_m      = 4'b0001 << lane;
        end else begin
            d_m = BAD_MASKS[$urandom_range(0, 8)];
        end
        d_pend = 1'b1;
    endtask

    task automatic put_d(input logic [31:0] a, input logic we, input logic [31:0] wd, input logic [3:0] m);
        d_a = a; d_we = we; d_wd = wd; d_m = m; d_pend = 1'b1;
    endtask

    // One clock cycle: drive after the rising edge, check on the falling edge,
    // then advance the model across the next rising edge.
    task automatic tick();
        logic        issuing, due, gi, gd;
        logic        e_ir, e_dr, e_iv, e_dv, e_ie, e_de, e_mreq;
        logic [31:0] e_ird, e_drd;

        @(posedge clk);
        #1;
        cyc++;
        if (i_pend && $urandom_range(0, 99) < p_drop) i_pend = 1'b0;
        else if (!i_pend && $urandom_range(0, 99) < p_i) new_i();
        if (d_pend && $urandom_range(0, 99) < p_drop) d_pend = 1'b0;
        else if (!d_pend && $urandom_range(0, 99) < p_d) new_d();

        issuing = t_open && !t_err && !t_acc;
        due     = t_open && !t_err && t_acc && (cyc == t_due);

        bus.i_i_req     = i_pend;
        bus.i_i_addr    = i_a;
        bus.i_d_req     = d_pend;
        bus.i_d_addr    = d_a;
        bus.i_d_wen     = d_we;
        bus.i_d_wdata   = d_wd;
        bus.i_d_mask    = d_m;
        bus.i_mem_ready = issuing ? ($urandom_range(0, 99) < p_rdy) : ($urandom_range(0, 1) == 1);
        bus.i_mem_valid = due || (issuing && $urandom_range(0, 99) < p_spur);
        bus.i_mem_rdata = due ? t_rd : $urandom();

        @(negedge clk);
        {e_ir, e_dr, e_iv, e_dv, e_ie, e_de, e_mreq} = '0;
        e_ird = '0;
        e_drd = '0;
        gi = 1'b0;
        gd = 1'b0;
        if (!t_open) begin
            if (d_pend && i_pend) begin
                if (streak >= int'(LIMIT)) gi = 1'b1; else gd = 1'b1;
            end else if (d_pend) gd = 1'b1;
            else if (i_pend) gi = 1'b1;
            e_ir = gi;
            e_dr = gd;
        end else if (t_err) begin
            if (t_own_d) begin e_dv = 1'b1; e_de = 1'b1; end
            else         begin e_iv = 1'b1; e_ie = 1'b1; end
        end else begin
            e_mreq = !t_acc;
            if (due) begin
                if (t_own_d) begin e_dv = 1'b1; e_drd = t_rd; end
                else         begin e_iv = 1'b1; e_ird = t_rd; end
            end
        end

        if (bus.o_mem_req) mreq_seen = 1'b1;
        chk("i_ready", 32'(bus.o_i_ready), 32'(e_ir));
        chk("d_ready", 32'(bus.o_d_ready), 32'(e_dr));
        chk("i_valid", 32'(bus.o_i_valid), 32'(e_iv));
        chk("d_valid", 32'(bus.o_d_valid), 32'(e_dv));
        chk("mem_req", 32'(bus.o_mem_req), 32'(e_mreq));
        chk("busy", 32'(busy), 32'(t_open));
        if (e_iv) begin
            chk("i_err", 32'(bus.o_i_err), 32'(e_ie));
            chk("i_rdata", bus.o_i_rdata, e_ird);
        end
        if (e_dv) begin
            chk("d_err", 32'(bus.o_d_err), 32'(e_de));
            chk("d_rdata", bus.o_d_rdata, e_drd);
        end
        if (e_mreq) begin
            chk("mem_addr", bus.o_mem_addr, {t_a[31:2], 2'b00});
            chk("mem_wen", 32'(bus.o_mem_wen), 32'(t_we));
            chk("mem_wdata", bus.o_mem_wdata, t_wd);
            chk("mem_mask", 32'(bus.o_mem_mask), 32'(t_m));
        end

        if (!t_open) begin
            if (gi || gd) begin
                t_open  = 1'b1;
                t_own_d = gd;
                t_acc   = 1'b0;
                gnt_cyc = cyc;
                gnt_log.push_back(bus.o_d_ready ? 1 : (bus.o_i_ready ? 0 : 2));
                if (gd) begin
                    t_a = d_a; t_we = d_we; t_wd = d_wd; t_m = d_m;
                    t_err  = mis_d(d_a, d_m);
                    d_pend = 1'b0;
                    if (i_pend && streak < int'(LIMIT)) streak++;
                end else begin
                    t_a = i_a; t_we = 1'b0; t_wd = '0; t_m = 4'hF;
                    t_err  = (i_a % 4) != 0;
                    i_pend = 1'b0;
                    streak = 0;
                end
            end
        end else if (t_err) begin
            rsp_cyc  = cyc;
            rsp_err  = t_own_d ? bus.o_d_err : bus.o_i_err;
            rsp_data = t_own_d ? bus.o_d_rdata : bus.o_i_rdata;
            t_open   = 1'b0;
        end else if (!t_acc) begin
            if (bus.i_mem_ready) begin
                t_acc     = 1'b1;
                t_due     = cyc + int'($urandom_range(lat_lo, lat_hi));
                acc_addr  = bus.o_mem_addr;
                acc_wen   = bus.o_mem_wen;
                acc_wdata = bus.o_mem_wdata;
                acc_mask  = bus.o_mem_mask;
                if (t_we) begin
                    logic [31:0] w;
                    w = mem_rd(t_a[31:2]);
                    for (int b = 0; b < 4; b++)
                        if (t_m[b]) w[8*b +: 8] = t_wd[8*b +: 8];
                    mem_q[t_a[31:2]] = w;
                    t_rd = $urandom();
                end else begin
                    t_rd = mem_rd(t_a[31:2]);
                end
            end
        end else if (due) begin
            rsp_cyc  = cyc;
            rsp_err  = t_own_d ? bus.o_d_err : bus.o_i_err;
            rsp_data = t_own_d ? bus.o_d_rdata : bus.o_i_rdata;
            t_open   = 1'b0;
        end
    endtask

    task automatic run_idle(input string tag, input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((t_open || i_pend || d_pend) && n < max);
        chk(tag, 32'(!(t_open || i_pend || d_pend)), 32'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ir"}, 32'(bus.o_i_ready), 32'd0);
        chk({tag, "_dr"}, 32'(bus.o_d_ready), 32'd0);
        chk({tag, "_iv"}, 32'(bus.o_i_valid), 32'd0);
        chk({tag, "_dv"}, 32'(bus.o_d_valid), 32'd0);
        chk({tag, "_ie"}, 32'(bus.o_i_err), 32'd0);
        chk({tag, "_de"}, 32'(bus.o_d_err), 32'd0);
        chk({tag, "_ird"}, bus.o_i_rdata, 32'd0);
        chk({tag, "_drd"}, bus.o_d_rdata, 32'd0);
        chk({tag, "_mreq"}, 32'(bus.o_mem_req), 32'd0);
        chk({tag, "_maddr"}, bus.o_mem_addr, 32'd0);
        chk({tag, "_mwen"}, 32'(bus.o_mem_wen), 32'd0);
        chk({tag, "_mwd"}, bus.o_mem_wdata, 32'd0);
        chk({tag, "_mmask"}, 32'(bus.o_mem_mask), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int n;

        // Reset held with both requests and a memory response pending
        bus.i_i_req = 1'b1; bus.i_i_addr = '0;
        bus.i_d_req = 1'b1; bus.i_d_addr = '0; bus.i_d_wen = 1'b0; bus.i_d_wdata = '0; bus.i_d_mask = 4'hF;
        bus.i_mem_ready = 1'b1; bus.i_mem_valid = 1'b1; bus.i_mem_rdata = 32'hFFFF_FFFF;
        #3;
        chk_all_zero("rst0");
        bus.i_i_req = 1'b0; bus.i_d_req = 1'b0; bus.i_mem_valid = 1'b0; bus.i_mem_ready = 1'b0;
        #4 rst_n = 1'b1;

        // Both requesting continuously: D,D,D,D,I repeating
        p_i = 100; p_d = 100; p_mis = 0; p_drop = 0; p_rdy = 100; lat_lo = 1; lat_hi = 1;
        gnt_log.delete();
        n = 0;
        while (gnt_log.size() < 10 && n < 200) begin tick(); n++; end
        chk("starve_bound", 32'(gnt_log.size() >= 10), 32'd1);
        for (int k = 0; k < 10 && k < gnt_log.size(); k++)
            chk($sformatf("starve_order%0d", k), 32'(gnt_log[k]), (k % 5 == 4) ? 32'd0 : 32'd1);
        p_i = 0; p_d = 0;
        run_idle("drain_starve", 50);

        // Aligned D load at 0x100: ready at T+1, valid at T+3
        mem_q[30'h40] = 32'hDEAD_BEEF;
        lat_lo = 2; lat_hi = 2;
        put_d(32'h100, 1'b0, 32'h0, 4'hF);
        run_idle("drain_ld", 20);
        chk("ld_lat", 32'(rsp_cyc - gnt_cyc), 32'd3);
        chk("ld_data", rsp_data, 32'hDEAD_BEEF);
        chk("ld_addr", acc_addr, 32'h100);
        chk("ld_wen", 32'(acc_wen), 32'd0);

        // Misaligned word store: error at T+1, memory untouched
        mreq_seen = 1'b0;
        put_d(32'h202, 1'b1, 32'h1234_5678, 4'hF);
        run_idle("drain_mis", 20);
        chk("mis_lat", 32'(rsp_cyc - gnt_cyc), 32'd1);
        chk("mis_err", 32'(rsp_err), 32'd1);
        chk("mis_data", rsp_data, 32'd0);
        chk("mis_noreq", 32'(mreq_seen), 32'd0);

        // Byte store to the top lane of 0x2000
        put_d(32'h2003, 1'b1, 32'hAB00_0000, 4'b1000);
        run_idle("drain_byte", 20);
        chk("byte_addr", acc_addr, 32'h2000);
        chk("byte_mask", 32'(acc_mask), 32'h8);
        chk("byte_wen", 32'(acc_wen), 32'd1);
        chk("byte_wdata", acc_wdata, 32'hAB00_0000);
        chk("byte_err", 32'(rsp_err), 32'd0);

        // Memory stalls in ISSUE for 5 cycles while a D request waits
        p_rdy = 0; lat_lo = 1; lat_hi = 1;
        i_a = 32'h44; i_pend = 1'b1;
        tick();
        put_d(32'h48, 1'b0, 32'h0, 4'hF);
        for (int k = 0; k < 5; k++) tick();
        chk("stall_req", 32'(bus.o_mem_req), 32'd1);
        chk("stall_addr", bus.o_mem_addr, 32'h44);
        p_rdy = 100;
        run_idle("drain_stall", 30);

        // Reset while in WAIT
        lat_lo = 20; lat_hi = 20;
        i_a = 32'h40; i_pend = 1'b1;
        n = 0;
        while (!(t_open && t_acc) && n < 20) begin tick(); n++; end
        chk("rst_wait_busy", 32'(busy), 32'd1);
        #1 rst_n = 1'b0;
        bus.i_i_req = 1'b1; bus.i_d_req = 1'b1; bus.i_mem_valid = 1'b1; bus.i_mem_ready = 1'b1;
        #1 chk_all_zero("rstw");
        @(posedge clk);
        #2;
        bus.i_i_req = 1'b0; bus.i_d_req = 1'b0; bus.i_mem_valid = 1'b0; bus.i_mem_ready = 1'b0;
        t_open = 1'b0; streak = 0; i_pend = 1'b0; d_pend = 1'b0;
        #1 rst_n = 1'b1;
        lat_lo = 1; lat_hi = 1;
        i_a = 32'h80; i_pend = 1'b1;
        tick();
        chk("rst_first_grant", 32'(gnt_cyc), 32'(cyc));
        run_idle("drain_rst", 20);

        // Randomized traffic
        p_i = 40; p_d = 50; p_mis = 15; p_drop = 5; p_rdy = 60; p_spur = 15; lat_lo = 1; lat_hi = 4;
        for (int k = 0; k < 3000; k++) tick();
        p_i = 0; p_d = 0; p_drop = 0;
        run_idle("drain_rand", 60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one multi-cycle unified memory port between the hart's instruction-fetch requester (port I) and data load/store requester (port D). This prepares the move away from the combinational imem/dmem ports.
- Handles one outstanding transaction at a time through an IDLE/ISSUE/WAIT/ERR state machine.
- Data requests have priority. A starvation guard bounds how long fetch can be held off.
- Misaligned addresses are rejected locally with an error response and never reach memory.

Parameters:
- STARVE_LIMIT, 4: number of consecutive conflicting D grants after which I wins the next conflict. Minimum 1.
- CNT_W, 3: width of the starvation counter. Must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_i_req  in  1  fetch request; held with i_i_addr until o_i_ready.
- i_i_addr  in  32  fetch address.
- o_i_ready  out  1  fetch request accepted this cycle.
- o_i_valid  out  1  fetch response this cycle.
- o_i_rdata  out  32  fetch response data.
- o_i_err  out  1  fetch response is an error; qualified by o_i_valid.
- i_d_req  in  1  data request; held with its fields until o_d_ready.
- i_d_addr  in  32  data address.
- i_d_wen  in  1  1 = store, 0 = load.
- i_d_wdata  in  32  store data, already lane-shifted.
- i_d_mask  in  4  byte-lane mask.
- o_d_ready  out  1  data request accepted this cycle.
- o_d_valid  out  1  data response this cycle.
- o_d_rdata  out  32  load data.
- o_d_err  out  1  data response is an error; qualified by o_d_valid.
- o_mem_req  out  1  memory request.
- o_mem_addr  out  32  memory address, word aligned.
- o_mem_wen  out  1  memory write enable.
- o_mem_wdata  out  32  memory write data.
- o_mem_mask  out  4  memory byte-lane mask.
- i_mem_ready  in  1  memory accepts the request this cycle.
- i_mem_valid  in  1  memory completion (reads and writes).
- i_mem_rdata  in  32  memory read data.
- o_busy  out  1  state != IDLE.

Behaviour:
- Reset (async assert, i_rst_n=0): state=IDLE, owner=I, starvation counter=0, latched request registers=0.
  - All o_* outputs are 0 while reset is asserted.
  - Reset mid-transaction silently drops the transaction; memory is reset by the same i_rst_n.
- Fetch requests are always treated as loads: wen=0, mask=4'b1111.
- IDLE:
  - If either request is asserted, exactly one is granted. o_X_ready=1 combinationally in that same cycle; the request fields are latched and owner is recorded.
  - Only D requesting: grant D.
  - Only I requesting: grant I.
  - Both requesting: grant D unless counter==STARVE_LIMIT, in which case grant I.
  - Alignment check on the granted request:
    - I: addr[1:0]!=0 is misaligned.
    - D word access (mask 4'b1111): addr[1:0]!=0 is misaligned.
    - D half access (mask 4'b0011 or 4'b1100): addr[0]!=0 is misaligned.
    - Any other D mask value that is not a single byte lane is misaligned.
  - Aligned grant -> ISSUE. Misaligned grant -> ERR.
  - No request: stay IDLE; both ready outputs 0.
- Starvation counter:
  - D granted while i_i_req=1: counter increments, saturating at STARVE_LIMIT.
  - I granted: counter clears to 0.
  - D granted while i_i_req=0: counter unchanged.
- ISSUE:
  - o_mem_req=1; o_mem_* driven from latched fields, with o_mem_addr = {addr[31:2],2'b00}.
  - i_mem_ready=1 -> WAIT. Otherwise stay in ISSUE with all fields held stable.
- WAIT:
  - o_mem_req=0.
  - i_mem_valid=1: o_<owner>_valid=1 in that same cycle, o_<owner>_rdata=i_mem_rdata, err=0; go to IDLE.
  - i_mem_valid asserted in the same cycle as i_mem_ready (while in ISSUE) is ignored. Memory must return valid no earlier than the cycle after ready.
- ERR (one cycle): o_<owner>_valid=1, o_<owner>_err=1, rdata=0, no memory access; go to IDLE.
- Minimum service latency: accept at cycle T, ISSUE at T+1 (memory ready at T+1), response at T+2.
  - The next accept is possible at T+3, since IDLE is re-entered after the response.
- The non-owner's ready and valid outputs remain 0 throughout a transaction.
- ready and valid are never asserted in the same cycle for the same port.
- A requester dropping its request before ready is legal; no grant results.

Test Plan:
- Aligned D load at 0x100, mem ready at T+1, valid at T+3 with rdata 0xDEADBEEF -> o_d_ready at T, o_mem_addr=0x100 with wen=0, o_d_valid with rdata=0xDEADBEEF at T+3.
- I and D both requesting continuously, STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I,...; counter reads 4 at each I grant, then 0.
- D word store to 0x202 -> o_d_valid=1 and o_d_err=1 at T+1; o_mem_req never asserted.
- D byte store to 0x2003 with mask 4'b1000 and wdata 0xAB000000 -> o_mem_addr=0x2000, o_mem_mask=4'b1000, o_mem_wen=1.
- i_mem_ready held low for 5 cycles during ISSUE -> o_mem_* stable for all 5 cycles; o_i_ready/o_d_ready stay 0 for new requests.
- i_rst_n driven low in WAIT -> outputs 0 immediately (async); after release, state IDLE and a fresh I request is granted in the first cycle.
